// File: rtl/pwm_seq.sv
// ---------------------------------------------------------------------------
// pwm_seq -- step-table sequencer for a single PWM core.
//
// Programs the PWM core's d/sel configuration port from a small table of
// steps. Each step holds {top, cmp, rep}. When a step is loaded, the block
// writes top, then cmp, and then (optionally) clears the PWM counter. It
// then dwells for max(rep,1) PWM period wraps. After that it moves to the
// next step. At the end of the table it either loops back to step 0 or
// pulses done and returns to idle.
//
// Configuration macro:
//   PWM_SEQ_SYNC_EN  When defined, every step load ends with a SYNC cycle
//                    that writes cnt=0, so each step starts on a fresh,
//                    aligned PWM period. When undefined, LD_CMP goes
//                    straight to RUN and the PWM counter free-runs across
//                    step changes.
//
// Parameters:
//   DEPTH  number of step-table entries (power of two, 2..16)
//   W      PWM data width (must match the PWM core)
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   wr_en     in   write one table entry this cycle
//   wr_addr   in   entry index to write
//   wr_top    in   period value for the entry
//   wr_cmp    in   compare value for the entry
//   wr_rep    in   periods to dwell on the entry (0 behaves as 1)
//   len       in   number of active steps, sampled on an accepted start
//   loop      in   wrap to step 0 after the last step, sampled on start
//   start     in   begin a sequence (idle only, len != 0)
//   stop      in   abort to idle; wins over start
//   pwm_wrap  in   one-cycle pulse from the PWM core on counter wrap
//   pwm_d     out  data to the PWM core d port
//   pwm_sel   out  PWM core sel: 00 none, 01 cmp, 10 top, 11 cnt
//   busy      out  high in every state except idle
//   step_idx  out  index of the current step (holds its value in idle)
//   done      out  one-cycle pulse at the end of a non-looping sequence
// ---------------------------------------------------------------------------
module pwm_seq #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_top,
  input  logic [W-1:0]             wr_cmp,
  input  logic [7:0]               wr_rep,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pwm_wrap,
  output logic [W-1:0]             pwm_d,
  output logic [1:0]               pwm_sel,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_CMP  = 2'b01;
  localparam logic [1:0] SEL_TOP  = 2'b10;
  localparam logic [1:0] SEL_CNT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_TOP = 3'd1,
    S_LD_CMP = 3'd2,
    S_SYNC   = 3'd3,
    S_RUN    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // -------------------------------------------------------------------------
  // Step table
  // -------------------------------------------------------------------------
  logic [W-1:0] top_mem [DEPTH];
  logic [W-1:0] cmp_mem [DEPTH];
  logic [7:0]   rep_mem [DEPTH];

  // NOTE: the table is deliberately left out of reset so it can map onto
  // plain RAM/regfile cells; a reset port would force it into flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      top_mem[wr_addr] <= wr_top;
      cmp_mem[wr_addr] <= wr_cmp;
      rep_mem[wr_addr] <= wr_rep;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer state
  // -------------------------------------------------------------------------
  state_t          state, state_n;
  logic [AW-1:0]   idx, idx_n;
  logic [AW:0]     len_q;
  logic            loop_q;
  logic [7:0]      rep_q;        // dwell of the current step, captured at load
  logic [7:0]      rep_cnt, rep_cnt_n;
  logic [1:0]      sel_n;
  logic [W-1:0]    d_n;

  logic            accept;
  logic            last_step;
  logic [7:0]      rep_eff;
  logic            dwell_met;

  assign accept    = (state == S_IDLE) && start && !stop && (len != '0);
  assign last_step = ({1'b0, idx} == (len_q - (AW+1)'(1)));
  assign rep_eff   = (rep_q == 8'd0) ? 8'd1 : rep_q;
  assign dwell_met = ((rep_cnt + 8'd1) == rep_eff);

  // Next-state logic.
  // NOTE: every variable driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    rep_cnt_n = rep_cnt;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_LD_TOP;
          idx_n   = '0;
        end
      end

      S_LD_TOP: state_n = S_LD_CMP;

      S_LD_CMP: begin
        rep_cnt_n = 8'd0;
`ifdef PWM_SEQ_SYNC_EN
        state_n   = S_SYNC;
`else
        state_n   = S_RUN;
`endif
      end

      S_SYNC: state_n = S_RUN;

      S_RUN: begin
        // Only wraps seen while in RUN count toward the dwell.
        if (pwm_wrap) begin
          rep_cnt_n = rep_cnt + 8'd1;
          if (dwell_met) begin
            if (!last_step) begin
              idx_n   = idx + AW'(1);
              state_n = S_LD_TOP;
            end else if (loop_q) begin
              idx_n   = '0;
              state_n = S_LD_TOP;
            end else begin
              state_n = S_DONE;
            end
          end
        end
      end

      S_DONE: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase

    // Abort beats everything, including a simultaneous start in idle.
    if (stop) begin
      state_n   = S_IDLE;
      idx_n     = idx;
      rep_cnt_n = rep_cnt;
    end
  end

  // Output values for the state being entered; registered below so the
  // outputs line up with the state they describe. The top read happens on
  // the edge that enters LD_TOP, so a write to the same entry on that edge
  // is not yet visible and the old top is driven.
  always_comb begin
    sel_n = SEL_NONE;
    d_n   = '0;
    unique case (state_n)
      S_LD_TOP: begin
        sel_n = SEL_TOP;
        d_n   = top_mem[idx_n];
      end
      S_LD_CMP: begin
        sel_n = SEL_CMP;
        d_n   = cmp_mem[idx_n];
      end
      S_SYNC: begin
        sel_n = SEL_CNT;
        d_n   = '0;
      end
      default: begin
        sel_n = SEL_NONE;
        d_n   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      rep_q    <= 8'd0;
      rep_cnt  <= 8'd0;
      pwm_d    <= '0;
      pwm_sel  <= SEL_NONE;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      rep_cnt <= rep_cnt_n;
      if (accept) begin
        len_q  <= len;
        loop_q <= loop;
      end
      // Dwell is captured with top, so rewriting the running entry does not
      // change the step already in progress.
      if (state_n == S_LD_TOP) begin
        rep_q <= rep_mem[idx_n];
      end
      pwm_sel <= sel_n;
      pwm_d   <= d_n;
      busy    <= (state_n != S_IDLE);
      done    <= (state_n == S_DONE);
    end
  end

  assign step_idx = idx;

endmodule

// File: tb/tb_pwm_seq.sv
// ---------------------------------------------------------------------------
// tb_pwm_seq -- self-checking bench for pwm_seq.
// A table model plus per-step expectations derived from the step rules
// (load top, load cmp, optional cnt clear, dwell of max(rep,1) wraps).
// ---------------------------------------------------------------------------
module tb_pwm_seq;

  localparam int DEPTH = 8;
  localparam int W     = 16;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_CMP  = 2'b01;
  localparam logic [1:0] SEL_TOP  = 2'b10;
  localparam logic [1:0] SEL_CNT  = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_top;
  logic [W-1:0]  wr_cmp;
  logic [7:0]    wr_rep;
  logic [AW:0]   len;
  logic          loop;
  logic          start;
  logic          stop;
  logic          pwm_wrap;
  logic [W-1:0]  pwm_d;
  logic [1:0]    pwm_sel;
  logic          busy;
  logic [AW-1:0] step_idx;
  logic          done;

  int checks   = 0;
  int failures = 0;

  // Reference copy of the step table.
  logic [W-1:0] m_top [DEPTH];
  logic [W-1:0] m_cmp [DEPTH];
  logic [7:0]   m_rep [DEPTH];

  typedef logic [2+W+1+AW+1-1:0] obs_t;
  obs_t obs;
  assign obs = {pwm_sel, pwm_d, busy, step_idx, done};

  pwm_seq #(.DEPTH(DEPTH), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_top   (wr_top),
    .wr_cmp   (wr_cmp),
    .wr_rep   (wr_rep),
    .len      (len),
    .loop     (loop),
    .start    (start),
    .stop     (stop),
    .pwm_wrap (pwm_wrap),
    .pwm_d    (pwm_d),
    .pwm_sel  (pwm_sel),
    .busy     (busy),
    .step_idx (step_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [1:0] s, input logic [W-1:0] d,
                              input logic b, input logic [AW-1:0] i,
                              input logic dn);
    return {s, d, b, i, dn};
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input int a, input logic [W-1:0] t,
                          input logic [W-1:0] c, input logic [7:0] r);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_top  = t;
    wr_cmp  = c;
    wr_rep  = r;
    tick();
    wr_en   = 1'b0;
    m_top[a] = t;
    m_cmp[a] = c;
    m_rep[a] = r;
  endtask

  // Starts a sequence and follows it step by step.
  //   noisy    : pulse pwm_wrap during idle/load cycles (must be ignored)
  //   stop_at  : raise stop after this many counted wraps (0 = never)
  //   wr_when  : 1 = rewrite entry 1 early in step 0's dwell,
  //              2 = rewrite entry 1 on the wrap that advances to step 1
  task automatic run_seq(input int n_len, input bit lp, input int n_steps,
                         input int gap_max, input bit noisy, input int stop_at,
                         input int wr_when, input logic [W-1:0] nt,
                         input logic [W-1:0] nc, input logic [7:0] nr);
    logic [W-1:0]  e_top;
    logic [7:0]    e_rep;
    logic [AW-1:0] idx;
    logic [AW-1:0] nidx;
    int            reff;
    int            gaps;
    int            total;
    bit            do_wr;
    obs_t          e;

    idx   = '0;
    nidx  = '0;
    total = 0;
    e_top = m_top[0];
    e_rep = m_rep[0];
    len      = (AW+1)'(n_len);
    loop     = lp;
    start    = 1'b1;
    pwm_wrap = noisy;
    tick();
    start = 1'b0;

    for (int s = 0; s < n_steps; s++) begin
      e = mk(SEL_TOP, e_top, 1'b1, idx, 1'b0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL ld_top step=%0d actual=%h expected=%h", s, obs, e);
      end
      pwm_wrap = noisy;
      tick();

      e = mk(SEL_CMP, m_cmp[idx], 1'b1, idx, 1'b0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL ld_cmp step=%0d actual=%h expected=%h", s, obs, e);
      end
      tick();
`ifdef PWM_SEQ_SYNC_EN
      e = mk(SEL_CNT, '0, 1'b1, idx, 1'b0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sync step=%0d actual=%h expected=%h", s, obs, e);
      end
      tick();
`endif
      pwm_wrap = 1'b0;
      reff = (e_rep == 8'd0) ? 1 : int'(e_rep);

      for (int w = 1; w <= reff; w++) begin
        e = mk(SEL_NONE, '0, 1'b1, idx, 1'b0);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL run step=%0d wrap=%0d actual=%h expected=%h", s, w, obs, e);
        end
        if (s == 0 && w == 1 && wr_when == 1) begin
          wr_entry(1, nt, nc, nr);
          checks++;
          if (obs !== e) begin
            failures++;
            $display("FAIL run_wr step=%0d actual=%h expected=%h", s, obs, e);
          end
        end
        gaps = int'($urandom_range(gap_max, 0));
        for (int g = 0; g < gaps; g++) begin
          tick();
          checks++;
          if (obs !== e) begin
            failures++;
            $display("FAIL run_gap step=%0d wrap=%0d actual=%h expected=%h", s, w, obs, e);
          end
        end
        do_wr = (s == 0 && w == reff && wr_when == 2);
        if (w == reff) begin
          nidx  = (int'(idx) < n_len - 1) ? idx + AW'(1) : '0;
          // Snapshot before any same-edge write: top/rep read old data.
          e_top = m_top[nidx];
          e_rep = m_rep[nidx];
        end
        if (do_wr) begin
          wr_en   = 1'b1;
          wr_addr = AW'(1);
          wr_top  = nt;
          wr_cmp  = nc;
          wr_rep  = nr;
        end
        pwm_wrap = 1'b1;
        tick();
        pwm_wrap = 1'b0;
        wr_en    = 1'b0;
        if (do_wr) begin
          m_top[1] = nt;
          m_cmp[1] = nc;
          m_rep[1] = nr;
        end
        total++;
        if (total == stop_at) begin
          stop = 1'b1;
          tick();
          stop = 1'b0;
          e = mk(SEL_NONE, '0, 1'b0, idx, 1'b0);
          checks++;
          if (obs !== e) begin
            failures++;
            $display("FAIL stop_run actual=%h expected=%h", obs, e);
          end
          return;
        end
      end
      idx = nidx;
    end

    if (!lp) begin
      e = mk(SEL_NONE, '0, 1'b1, AW'(n_len - 1), 1'b1);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL done_pulse actual=%h expected=%h", obs, e);
      end
      tick();
      e = mk(SEL_NONE, '0, 1'b0, AW'(n_len - 1), 1'b0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL done_idle actual=%h expected=%h", obs, e);
      end
      tick();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL idle_hold actual=%h expected=%h", obs, e);
      end
    end else begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
      e = mk(SEL_NONE, '0, 1'b0, idx, 1'b0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL stop_loop actual=%h expected=%h", obs, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_hold actual=%h expected=%h", obs, obs_t'(0));
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_idle actual=%h expected=%h", obs, obs_t'(0));
    end
  endtask

  task automatic test_two_step();
    wr_entry(0, 16'd99, 16'd49, 8'd2);
    wr_entry(1, 16'd9, 16'd3, 8'd1);
    run_seq(2, 1'b0, 2, 2, 1'b0, 0, 0, '0, '0, 8'd0);
  endtask

  task automatic test_len_zero_and_noise();
    obs_t e;
    // Previous sequence ended on step 1, which idle must hold.
    e = mk(SEL_NONE, '0, 1'b0, AW'(1), 1'b0);
    len   = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL len_zero cycle=%0d actual=%h expected=%h", i, obs, e);
      end
      tick();
    end
    wr_entry(0, W'($urandom()), W'($urandom()), 8'd3);
    run_seq(1, 1'b0, 1, 1, 1'b1, 0, 0, '0, '0, 8'd0);
  endtask

  task automatic test_stop();
    obs_t e;
    wr_entry(0, W'($urandom()), W'($urandom()), 8'd3);
    run_seq(1, 1'b0, 1, 1, 1'b0, 1, 0, '0, '0, 8'd0);
    e = mk(SEL_NONE, '0, 1'b0, '0, 1'b0);
    len   = (AW+1)'(1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL start_stop cycle=%0d actual=%h expected=%h", i, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_loop();
    wr_entry(0, W'($urandom()), W'($urandom()), 8'd0);
    run_seq(1, 1'b1, 5, 2, 1'b0, 0, 0, '0, '0, 8'd0);
  endtask

  task automatic test_write_during_run();
    wr_entry(0, W'($urandom()), W'($urandom()), 8'd2);
    wr_entry(1, W'($urandom()), W'($urandom()), 8'd2);
    run_seq(2, 1'b0, 2, 1, 1'b0, 0, 1, W'($urandom()), W'($urandom()), 8'd1);
    wr_entry(1, W'($urandom()), W'($urandom()), 8'd2);
    run_seq(2, 1'b0, 2, 1, 1'b0, 0, 2, W'($urandom()), W'($urandom()), 8'd3);
  endtask

  task automatic test_reset_mid_run();
    obs_t e;
    wr_entry(0, W'($urandom()), W'($urandom()), 8'd1);
    wr_entry(1, W'($urandom()), W'($urandom()), 8'd5);
    len   = (AW+1)'(2);
    loop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
`ifdef PWM_SEQ_SYNC_EN
    tick();
`endif
    pwm_wrap = 1'b1;
    tick();
    pwm_wrap = 1'b0;
    tick();
    tick();
`ifdef PWM_SEQ_SYNC_EN
    tick();
`endif
    e = mk(SEL_NONE, '0, 1'b1, AW'(1), 1'b0);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL pre_reset actual=%h expected=%h", obs, e);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL async_reset actual=%h expected=%h", obs, obs_t'(0));
    end
    #2 rst = 1'b0;
    tick();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL post_reset actual=%h expected=%h", obs, obs_t'(0));
    end
  endtask

  task automatic test_random_seq();
    int n;
    bit lp;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < DEPTH; a++)
        wr_entry(a, W'($urandom()), W'($urandom()), 8'($urandom_range(3, 0)));
      n  = int'($urandom_range(DEPTH, 1));
      lp = 1'($urandom_range(1, 0));
      run_seq(n, lp, lp ? n + 2 : n, 2, 1'($urandom_range(1, 0)), 0, 0,
              '0, '0, 8'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_top   = '0;
    wr_cmp   = '0;
    wr_rep   = '0;
    len      = '0;
    loop     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    pwm_wrap = 1'b0;

    test_reset();
    test_two_step();
    test_len_zero_and_noise();
    test_stop();
    test_loop();
    test_write_during_run();
    test_reset_mid_run();
    test_random_seq();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_seq.md
# pwm_seq

Sequencer that programs one PWM core through its `d`/`sel` configuration port from a small on-chip step table. Each step holds a (top, cmp) pair and a repeat count in PWM periods. The block loads a step and counts PWM period wraps. It then advances to the next step, and either stops or loops at the end of the table. It sits between a host register interface and the PWM core.

## Interface
Parameters:
- `DEPTH`, 8: number of step-table entries (power of two, 2..16).
- `W`, 16: PWM data width; must match the PWM core.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  write one table entry this cycle.
- `wr_addr`  in  $clog2(DEPTH)  entry index.
- `wr_top`  in  W  period value for entry.
- `wr_cmp`  in  W  compare value for entry.
- `wr_rep`  in  8  periods to dwell on entry; 0 is treated as 1.
- `len`  in  $clog2(DEPTH)+1  number of active steps, sampled on accepted `start`.
- `loop`  in  1  wrap to step 0 after last step, sampled on accepted `start`.
- `start`  in  1  begin sequence; accepted only in IDLE with `len` != 0.
- `stop`  in  1  abort; wins over `start`.
- `pwm_wrap`  in  1  one-cycle pulse from PWM core when its counter wraps (out rises).
- `pwm_d`  out  W  data to PWM core `d`.
- `pwm_sel`  out  2  PWM core `sel`: 00 none, 01 cmp, 10 top, 11 cnt.
- `busy`  out  1  high in any state except IDLE.
- `step_idx`  out  $clog2(DEPTH)  index of current step.
- `done`  out  1  one-cycle pulse at end of a non-looping sequence.

## Operation
- Table: DEPTH entries of {top, cmp, rep}, written synchronously on `wr_en` in any state. A step-load read in the same cycle as a write to that entry returns the old value. Table is not reset.
- FSM states: IDLE, LD_TOP, LD_CMP, [SYNC], RUN, DONE.
- IDLE: `start` & !`stop` & `len`!=0 -> LD_TOP. Latch `len` and `loop`, and set `step_idx`=0. `start` with `len`=0 is ignored.
- LD_TOP: `pwm_sel`=10, `pwm_d`=top[idx]. Goes to LD_CMP.
- LD_CMP: `pwm_sel`=01, `pwm_d`=cmp[idx]. Goes to SYNC if the macro is defined, else RUN. The repeat counter clears to 0.
- SYNC: `pwm_sel`=11, `pwm_d`=0. Goes to RUN.
- RUN: `pwm_sel`=00, `pwm_d`=0. Each `pwm_wrap` increments the 8-bit repeat counter. On the wrap that makes the count equal to max(rep[idx],1), one of three things happens:
  - idx < len-1: idx+1, go to LD_TOP.
  - last step and loop=1: idx=0, go to LD_TOP.
  - last step and loop=0: go to DONE.
- DONE: `done`=1 for this cycle only. Goes to IDLE. PWM keeps the last loaded config.
- `pwm_wrap` outside RUN is ignored and not counted.
- `stop` in any state -> IDLE next cycle. `pwm_sel`=00 and `done` is not asserted. PWM keeps its last config.
- `step_idx` holds its last value in IDLE.

## Timing
- Reset values: `pwm_d`=0, `pwm_sel`=00, `busy`=0, `step_idx`=0, `done`=0, state IDLE, repeat counter 0.
- All outputs are registered and reflect the current state.
- `start` sampled at edge k means LD_TOP is visible in cycle k+1 and LD_CMP in k+2. RUN begins at k+3, or at k+4 with SYNC.
- Step-to-step reload cost is 2 cycles, or 3 with SYNC, of `pwm_sel`!=00 after the advancing wrap edge.
- `busy` rises the cycle after accepted `start`. It falls the cycle after DONE or after `stop`.

## Configuration
- `PWM_SEQ_SYNC_EN` defined: the SYNC state exists. Every step load ends by writing cnt=0, so each new step starts on a fresh, aligned period.
- `PWM_SEQ_SYNC_EN` not defined: there is no SYNC state and LD_CMP goes directly to RUN. The PWM counter free-runs across step changes.

## Test plan
- Reset mid-RUN: assert `rst` asynchronously -> all outputs return to reset values immediately; `busy`=0.
- Two-step sequence, entries {top=99,cmp=49,rep=2} and {top=9,cmp=3,rep=1}, len=2, loop=0, start -> `pwm_sel`/`pwm_d` sequence 10/99, 01/49, [11/0]. Then 2 wraps, then 10/9, 01/3, [11/0]. Then 1 wrap, then `done` pulses once and `busy` falls.
- loop=1, len=1, rep=0 -> reload of entry 0 after every single wrap, indefinitely; `done` never asserts.
- `stop` in RUN after 1 of 3 wraps -> IDLE next cycle, `pwm_sel`=00, no `done`; `start` and `stop` together in IDLE -> stays IDLE.
- `start` with `len`=0 -> no state change; `pwm_wrap` pulses in IDLE and LD_TOP -> not counted (dwell still needs full rep wraps in RUN).
- Write entry 1 while step 0 runs -> new values appear when step 1 loads; write in the same cycle as the LD_TOP read of that entry -> old top is driven.
